fdiv_iter: RTL and testbench



---
 rtl/fp_pkg.sv | 45 ++++
 rtl/fp_mant_div_step.sv | 22 ++
 rtl/fdiv_iter.sv | 197 +++++++++++++++++++
 tb/tb_fdiv_iter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the iterative floating-point divider: FSM states,
// flag bit positions and field helpers that work on a zero-extended word.
package fp_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} fdiv_state_e;

   localparam int FLAG_NV  = 3;
   localparam int FLAG_DZ  = 2;
   localparam int FLAG_OVF = 1;
   localparam int FLAG_UF  = 0;

   // Helpers take any format up to this width; callers zero-extend and truncate.
   localparam int FP_MAX_W = 64;
   typedef logic [FP_MAX_W-1:0] fp_word_t;

   function automatic fp_word_t exp_ones(input int exp_w);
      return (fp_word_t'(1) << exp_w) - fp_word_t'(1);
   endfunction

   function automatic fp_word_t exp_field(input fp_word_t word, input int exp_w, input int mant_w);
      return (word >> mant_w) & exp_ones(exp_w);
   endfunction

   // Denormals carry a zero exponent and are deliberately treated as zero.
   function automatic logic is_zero(input fp_word_t word, input int exp_w, input int mant_w);
      return exp_field(word, exp_w, mant_w) == '0;
   endfunction

   function automatic logic is_special(input fp_word_t word, input int exp_w, input int mant_w);
      return exp_field(word, exp_w, mant_w) == exp_ones(exp_w);
   endfunction

   function automatic fp_word_t qnan(input int exp_w, input int mant_w);
      return (exp_ones(exp_w) << mant_w) | (fp_word_t'(1) << (mant_w - 1));
   endfunction

   function automatic fp_word_t inf(input logic sign, input int exp_w, input int mant_w);
      return (fp_word_t'(sign) << (exp_w + mant_w)) | (exp_ones(exp_w) << mant_w);
   endfunction

   function automatic fp_word_t zero(input logic sign, input int exp_w, input int mant_w);
      return fp_word_t'(sign) << (exp_w + mant_w);
   endfunction

endpackage

// File: rtl/fp_mant_div_step.sv
// One restoring-division step: compare the partial remainder against the
// divisor, subtract when it fits, and shift for the next quotient bit.
module fp_mant_div_step #(
   parameter int MANT_W = 23
) (
   input  logic [MANT_W+1:0] rem,
   input  logic [MANT_W:0]   divisor,
   output logic [MANT_W+1:0] rem_next,
   output logic              q_bit
);

   logic [MANT_W+1:0] diff;

   // The remainder stays below twice the divisor, so the shifted value never
   // needs an extra bit.
   always_comb begin
      diff     = rem - {1'b0, divisor};
      q_bit    = (rem >= {1'b0, divisor});
      rem_next = q_bit ? {diff[MANT_W:0], 1'b0} : {rem[MANT_W:0], 1'b0};
   end

endmodule

// File: rtl/fdiv_iter.sv
// Iterative IEEE-754-style divider: special operands resolve at accept, normal
// operands run one restoring step per clock and pack a truncated quotient.
module fdiv_iter
   import fp_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23,
   parameter int BIAS   = 2**(EXP_W-1)-1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [EXP_W+MANT_W:0] in_a,
   input  logic [EXP_W+MANT_W:0] in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [EXP_W+MANT_W:0] out_result,
   output logic [3:0]            out_flags
);

   localparam int W  = 1 + EXP_W + MANT_W;
   localparam int RW = MANT_W + 2;
   localparam int EW = EXP_W + 2;
   localparam int CW = $clog2(MANT_W + 2);

   localparam logic [CW-1:0]        CNT_LAST = CW'(MANT_W + 1);
   localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
   localparam logic signed [EW-1:0] E_MAX    = EW'((2**EXP_W) - 1);
   localparam logic signed [EW-1:0] E_ZERO   = '0;
   localparam logic signed [EW-1:0] E_ONE    = EW'(1);
   localparam logic signed [EW-1:0] E_BIAS   = EW'(BIAS);

   fdiv_state_e state_reg, state_next;

   logic              sign_reg;
   logic [EXP_W-1:0]  ea_reg, eb_reg;
   logic [MANT_W-1:0] fb_reg;
   logic [CW-1:0]     cnt_reg;
   logic [RW-1:0]     rem_reg;
   logic [MANT_W:0]   quot_reg;
   logic [W-1:0]      result_reg;
   logic [3:0]        flags_reg;

   logic accept;
   logic last;

   // ---------------- operand classification at accept ----------------
   fp_word_t     a_word, b_word;
   logic         a_zero, b_zero, a_spec, b_spec, sign_in, special;
   logic [W-1:0] special_result;
   logic [3:0]   special_flags;

   always_comb begin
      a_word         = fp_word_t'(in_a);
      b_word         = fp_word_t'(in_b);
      a_zero         = is_zero(a_word, EXP_W, MANT_W);
      b_zero         = is_zero(b_word, EXP_W, MANT_W);
      a_spec         = is_special(a_word, EXP_W, MANT_W);
      b_spec         = is_special(b_word, EXP_W, MANT_W);
      sign_in        = in_a[W-1] ^ in_b[W-1];
      special        = 1'b1;
      special_result = '0;
      special_flags  = '0;
      if (a_spec || b_spec || (a_zero && b_zero)) begin
         special_result          = W'(qnan(EXP_W, MANT_W));
         special_flags[FLAG_NV]  = 1'b1;
      end else if (b_zero) begin
         special_result          = W'(inf(sign_in, EXP_W, MANT_W));
         special_flags[FLAG_DZ]  = 1'b1;
      end else if (a_zero) begin
         special_result          = W'(zero(sign_in, EXP_W, MANT_W));
      end else begin
         special                 = 1'b0;
      end
   end

   // ---------------- mantissa iteration ----------------
   logic [RW-1:0] rem_next;
   logic          q_bit;

   fp_mant_div_step #(
      .MANT_W (MANT_W)
   ) u_step (
      .rem      (rem_reg),
      .divisor  ({1'b1, fb_reg}),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   // ---------------- normalise, range-check and pack ----------------
   logic [MANT_W+1:0]    quot_full;
   logic [MANT_W-1:0]    frac;
   logic signed [EW-1:0] e_base, e_norm;
   logic [W-1:0]         calc_result;
   logic [3:0]           calc_flags;

   always_comb begin
      quot_full   = {quot_reg, q_bit};
      e_base      = $signed({2'b00, ea_reg}) - $signed({2'b00, eb_reg}) + E_BIAS;
      frac        = quot_full[MANT_W:1];
      e_norm      = e_base;
      calc_flags  = '0;
      // Quotient is in (0.5, 2): a clear MSB means one left shift is needed.
      if (!quot_full[MANT_W+1]) begin
         frac   = quot_full[MANT_W-1:0];
         e_norm = e_base - E_ONE;
      end
      if (e_norm >= E_MAX) begin
         calc_result          = W'(inf(sign_reg, EXP_W, MANT_W));
         calc_flags[FLAG_OVF] = 1'b1;
      end else if (e_norm <= E_ZERO) begin
         calc_result          = W'(zero(sign_reg, EXP_W, MANT_W));
         calc_flags[FLAG_UF]  = 1'b1;
      end else begin
         calc_result          = {sign_reg, e_norm[EXP_W-1:0], frac};
      end
   end

   // ---------------- control FSM ----------------
   assign accept = in_valid && in_ready;
   assign last   = (state_reg == CALC) && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // in_ready is gated by rst_n so nothing is offered while reset is held.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid && rst_n) begin
               state_next = special ? DONE : CALC;
            end
         end
         CALC: begin
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_reg   <= 1'b0;
         ea_reg     <= '0;
         eb_reg     <= '0;
         fb_reg     <= '0;
         cnt_reg    <= '0;
         rem_reg    <= '0;
         quot_reg   <= '0;
         result_reg <= '0;
         flags_reg  <= '0;
      end else if (accept) begin
         sign_reg <= sign_in;
         ea_reg   <= in_a[W-2:MANT_W];
         eb_reg   <= in_b[W-2:MANT_W];
         fb_reg   <= in_b[MANT_W-1:0];
         rem_reg  <= {2'b01, in_a[MANT_W-1:0]};
         cnt_reg  <= '0;
         quot_reg <= '0;
         if (special) begin
            result_reg <= special_result;
            flags_reg  <= special_flags;
         end
      end else if (state_reg == CALC) begin
         rem_reg  <= rem_next;
         quot_reg <= {quot_reg[MANT_W-1:0], q_bit};
         cnt_reg  <= cnt_reg + CNT_ONE;
         if (last) begin
            result_reg <= calc_result;
            flags_reg  <= calc_flags;
         end
      end
   end

   assign out_result = result_reg;
   assign out_flags  = flags_reg;

endmodule

// File: tb/tb_fdiv_iter.sv
// Scoreboarded bench for fdiv_iter: directed cases plus random operands against
// an integer-division reference model; a monitor checks every delivered result.
module tb_fdiv_iter;

   localparam int EXP_W    = 8;
   localparam int MANT_W   = 23;
   localparam int W        = 1 + EXP_W + MANT_W;
   localparam int BIAS     = 127;
   localparam int NORM_LAT = MANT_W + 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_result;
   logic [3:0]   out_flags;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [W-1:0] res;
      logic [3:0]   flags;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   fdiv_iter #(
      .EXP_W  (EXP_W),
      .MANT_W (MANT_W),
      .BIAS   (BIAS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: exact integer quotient of the significands, truncated.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] res, output logic [3:0] fl,
                                 output bit special);
      int ea, eb, e;
      logic s;
      longint unsigned ma, mb, q, frac;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      fl = 4'b0000;
      special = 1'b1;
      res = '0;
      if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) begin
         res = 32'h7FC0_0000;
         fl  = 4'b1000;
      end else if (eb == 0) begin
         res = {s, 8'hFF, 23'h0};
         fl  = 4'b0100;
      end else if (ea == 0) begin
         res = {s, 31'h0};
      end else begin
         special = 1'b0;
         ma = 64'(a[22:0]) + 64'h80_0000;
         mb = 64'(b[22:0]) + 64'h80_0000;
         q  = (ma << 24) / mb;          // quotient scaled by 2^24
         e  = ea - eb + BIAS;
         if (q >= 64'h100_0000) begin
            frac = (q >> 1) & 64'h7F_FFFF;
         end else begin
            frac = q & 64'h7F_FFFF;
            e    = e - 1;
         end
         if (e >= 255) begin
            res = {s, 8'hFF, 23'h0};
            fl  = 4'b0010;
         end else if (e <= 0) begin
            res = {s, 31'h0};
            fl  = 4'b0001;
         end else begin
            res = {s, 8'(e), 23'(frac)};
         end
      end
   endfunction

   function automatic logic [W-1:0] rand_fp();
      int k;
      logic [7:0] e;
      k = $urandom_range(0, 19);
      if (k == 0)      e = 8'h00;
      else if (k == 1) e = 8'hFF;
      else if (k <= 3) e = 8'($urandom_range(1, 12));
      else if (k <= 5) e = 8'($urandom_range(243, 254));
      else             e = 8'($urandom_range(1, 254));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   // Monitor: a result transfers on the edge after out_valid && out_ready.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: actual 0x%0h required no result", out_result);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", 64'(out_result), 64'(mon_e.res));
            check("flags", 64'(out_flags), 64'(mon_e.flags));
         end
      end
   end

   // Driver: issue one operation, check latency/backpressure, optionally abort via reset.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input int abort_at);
      logic [W-1:0] r;
      logic [3:0]   f;
      bit           sp;
      int           t;
      int           lat;
      model(a, b, r, f, sp);
      t = 0;
      while (!in_ready && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      check("in_ready_before_issue", 64'(in_ready), 64'd1);
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back('{res: r, flags: f});
      #1;
      if (abort_at > 0) begin
         in_valid = 1'b0;
         repeat (abort_at - 1) @(posedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         check("abort_out_valid", 64'(out_valid), 64'd0);
         check("abort_in_ready", 64'(in_ready), 64'd0);
         void'(exp_q.pop_back());
         repeat (2) @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         #1;
         check("release_in_ready", 64'(in_ready), 64'd1);
         @(posedge clk); #1;
         return;
      end
      // Garbage offered while busy must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      in_a = W'($urandom);
      in_b = W'($urandom);
      lat = 1;
      while (!out_valid && lat < 200) begin
         check("busy_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 64'(lat), sp ? 64'd1 : 64'(NORM_LAT));
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_result", 64'(out_result), 64'(r));
         check("hold_flags", 64'(out_flags), 64'(f));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_out_valid", 64'(out_valid), 64'd0);
      check("post_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd0);
      check("reset_result", 64'(out_result), 64'd0);
      check("reset_flags", 64'(out_flags), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      run_op(32'h40C0_0000, 32'h4000_0000, 10, 0);   // 6/2 with backpressure
      run_op(32'h40C0_0000, 32'h4000_0000, 0, 0);    // back-to-back
      run_op(32'h3F80_0000, 32'h4040_0000, 1, 0);    // 1/3
      run_op(32'hBF80_0000, 32'h4040_0000, 0, 0);    // -1/3
      run_op(32'h3F80_0000, 32'h0000_0000, 2, 0);    // divide by zero
      run_op(32'h0000_0000, 32'h0000_0000, 0, 0);    // 0/0
      run_op(32'h8000_0000, 32'h4000_0000, 0, 0);    // -0/2
      run_op(32'h7F00_0000, 32'h0080_0000, 0, 0);    // overflow
      run_op(32'h0080_0000, 32'h7F00_0000, 0, 0);    // underflow
      run_op(32'h40C0_0000, 32'h4000_0000, 0, 10);   // reset at cycle 10
      run_op(32'h3F80_0000, 32'h4040_0000, 0, 0);    // recovery 1/3

      for (int n = 0; n < 60; n++) begin
         run_op(rand_fp(), rand_fp(), $urandom_range(0, 3), 0);
      end

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
